id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between the decode stage (opcode decoder plus register file read) and the execute stage of the RV32I core. Captures the decoded control bundle, operands, immediate and register indices every cycle. Detects load-use hazards against the instruction currently in EX and inserts bubbles. Honours execute-side hold and branch/jump flush requests, and keeps a saturating count of inserted bubbles.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, bubble counter width

- iClk  in  1  clock, all state on rising edge
- iRst  in  1  synchronous, active-high reset
- iValid  in  1  decode slot holds a real instruction
- iLui, iPcSrc, iMemRd, iMemWr, iMemtoReg, iAluSrc1, iAluSrc2, iRegWrite, iBranch, iJump  in  1 each  decoded control bits
- iAluOp  in  3  decoded ALU class
- iPc, iRs1Data, iRs2Data, iImm  in  XLEN each  decode-stage PC, operands, sign-extended immediate
- iRs1, iRs2, iRd  in  5 each  register indices
- iFunct3  in  3; iFunct7b5  in  1  ALU sub-op fields
- iExStall  in  1  execute/memory side cannot accept a new instruction
- iFlush  in  1  taken branch/jump resolved in EX; kill the decode instruction
- oValid  out  1  EX slot valid
- oLui … oJump, oAluOp, oPc, oRs1Data, oRs2Data, oImm, oRs1, oRs2, oRd, oFunct3, oFunct7b5  out  registered copies of the matching inputs
- oStall  out  1  combinational; freeze PC and IF/ID this cycle
- oBubbleCnt  out  CNT_W  saturating count of load-use bubbles inserted

## Operation
- Source usage is derived from the decoded control bits:
  - useRs1 = ~(iLui | iAluSrc1). This excludes LUI, JAL and AUIPC.
  - useRs2 = ~iLui & (~iAluSrc2 | iMemWr). This covers R-type, branch and store.
- Load-use hazard: loadUse = iValid & oValid & oMemRd & (oRd != 0) & ((useRs1 & oRd == iRs1) | (useRs2 & oRd == iRs2)).
- Per-cycle action, highest priority first:
  - iRst: all outputs go to 0.
  - iFlush: EX slot becomes a bubble.
  - iExStall: all registers hold.
  - loadUse: EX slot becomes a bubble, oBubbleCnt increments.
  - Otherwise: load every field from the inputs; oValid = iValid.
- Bubble: oValid and all control outputs are cleared (oAluOp = 0). Data, index and PC fields hold their previous values and are don't-care when oValid = 0.
- When iValid = 0 and no other condition applies, the control outputs are loaded as 0 regardless of the control inputs.
- oStall = ~iFlush & (loadUse | iExStall).
- oBubbleCnt stops at 2^CNT_W−1. Flush bubbles are not counted.

## Timing
- Latency: 1 cycle from decode inputs to registered outputs.
- Reset values: every output is 0, including oBubbleCnt. oStall is 0 while iRst is high.
- Load-use stall lasts exactly 1 cycle per hazard. On the next cycle the load has left EX and the dependent instruction is loaded.
- iExStall held for N cycles:
  - Outputs are frozen for N cycles.
  - oStall stays high for those N cycles.
  - No bubble is inserted and the counter does not change.
- iFlush together with loadUse: the flush wins, no count, oStall = 0.
- iFlush together with iExStall: the flush wins and the EX slot is cleared.
- Reset asserted mid-stall: the next cycle is the reset state. The hazard is forgotten.
- A load with oRd = x0 never stalls.

## Structure
- Shared package ctrl_pkg holds:
  - the opcode localparams;
  - the ALU-op encodings (000 add, 001 branch compare, 010 R-type, 011 I-type);
  - the control bundle width and field offsets, shared with the decoder and the EX stage.
- Sub-module hazard_unit (combinational) computes useRs1, useRs2 and loadUse. It will be reused by a future forwarding unit.
- The top level holds the register bank, the priority mux and the bubble counter.

## Test plan
- **Reset:** hold iRst 2 cycles with all inputs high → every output 0, oStall 0.
- **Load-use on rs1:** EX holds LW x5 (oMemRd = 1, oRd = 5); decode presents ADD x6,x5,x1 → oStall = 1 for 1 cycle, then oValid = 0 with all control outputs 0, oBubbleCnt = 1. On the following cycle oRd = 6 and oRegWrite = 1.
- **No false hazard:**
  - EX holds LW x0 → decode ADD x6,x0,x0 gives oStall = 0.
  - EX holds LW x5 → decode LUI x5 gives oStall = 0.
  - EX holds LW x5 → decode ADDI x7,x1,5 (uses rs1 = x1 only) gives oStall = 0.
- **Store on rs2:** EX LW x3 → decode SW x3,0(x2) → stall with 1 bubble.
- **Hold then flush:**
  - iExStall for 3 cycles → outputs unchanged, oStall = 1 for all 3 cycles.
  - Then iFlush with loadUse also true → oValid = 0 next cycle, oStall = 0, counter unchanged.
- **Saturation:** with CNT_W = 2, force 5 load-use hazards → oBubbleCnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Control-bundle definitions shared by the decoder, the ID/EX register and the EX stage.
// Opcodes, ALU-class encodings and the packed control bundle layout live here.
package ctrl_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [2:0] ALU_ADD    = 3'b000;
   localparam logic [2:0] ALU_BRANCH = 3'b001;
   localparam logic [2:0] ALU_RTYPE  = 3'b010;
   localparam logic [2:0] ALU_ITYPE  = 3'b011;

   // Bit offsets of each field inside the packed bundle (LSB first).
   localparam int CTRL_W           = 13;
   localparam int CTRL_ALUOP_LSB   = 0;
   localparam int CTRL_JUMP        = 3;
   localparam int CTRL_BRANCH      = 4;
   localparam int CTRL_REGWRITE    = 5;
   localparam int CTRL_ALUSRC2     = 6;
   localparam int CTRL_ALUSRC1     = 7;
   localparam int CTRL_MEMTOREG    = 8;
   localparam int CTRL_MEMWR       = 9;
   localparam int CTRL_MEMRD       = 10;
   localparam int CTRL_PCSRC       = 11;
   localparam int CTRL_LUI         = 12;

   typedef struct packed {
      logic       lui;
      logic       pc_src;
      logic       mem_rd;
      logic       mem_wr;
      logic       mem_to_reg;
      logic       alu_src1;
      logic       alu_src2;
      logic       reg_write;
      logic       branch;
      logic       jump;
      logic [2:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = ctrl_t'({CTRL_W{1'b0}});

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decode-side inputs and the registered EX-slot outputs.
interface id_ex_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             iValid;
   logic             iLui, iPcSrc, iMemRd, iMemWr, iMemtoReg;
   logic             iAluSrc1, iAluSrc2, iRegWrite, iBranch, iJump;
   logic [2:0]       iAluOp;
   logic [XLEN-1:0]  iPc, iRs1Data, iRs2Data, iImm;
   logic [4:0]       iRs1, iRs2, iRd;
   logic [2:0]       iFunct3;
   logic             iFunct7b5;
   logic             iExStall;
   logic             iFlush;

   logic             oValid;
   logic             oLui, oPcSrc, oMemRd, oMemWr, oMemtoReg;
   logic             oAluSrc1, oAluSrc2, oRegWrite, oBranch, oJump;
   logic [2:0]       oAluOp;
   logic [XLEN-1:0]  oPc, oRs1Data, oRs2Data, oImm;
   logic [4:0]       oRs1, oRs2, oRd;
   logic [2:0]       oFunct3;
   logic             oFunct7b5;
   logic             oStall;
   logic [CNT_W-1:0] oBubbleCnt;

   modport master (
      output iValid, iLui, iPcSrc, iMemRd, iMemWr, iMemtoReg, iAluSrc1, iAluSrc2,
             iRegWrite, iBranch, iJump, iAluOp, iPc, iRs1Data, iRs2Data, iImm,
             iRs1, iRs2, iRd, iFunct3, iFunct7b5, iExStall, iFlush,
      input  oValid, oLui, oPcSrc, oMemRd, oMemWr, oMemtoReg, oAluSrc1, oAluSrc2,
             oRegWrite, oBranch, oJump, oAluOp, oPc, oRs1Data, oRs2Data, oImm,
             oRs1, oRs2, oRd, oFunct3, oFunct7b5, oStall, oBubbleCnt
   );

   modport slave (
      input  iValid, iLui, iPcSrc, iMemRd, iMemWr, iMemtoReg, iAluSrc1, iAluSrc2,
             iRegWrite, iBranch, iJump, iAluOp, iPc, iRs1Data, iRs2Data, iImm,
             iRs1, iRs2, iRd, iFunct3, iFunct7b5, iExStall, iFlush,
      output oValid, oLui, oPcSrc, oMemRd, oMemWr, oMemtoReg, oAluSrc1, oAluSrc2,
             oRegWrite, oBranch, oJump, oAluOp, oPc, oRs1Data, oRs2Data, oImm,
             oRs1, oRs2, oRd, oFunct3, oFunct7b5, oStall, oBubbleCnt
   );
endinterface

// File: rtl/hazard_unit.sv
// Load-use hazard detection between the decode instruction and the load sitting in EX.
module hazard_unit (
   input  logic       valid,
   input  logic       lui,
   input  logic       alu_src1,
   input  logic       alu_src2,
   input  logic       mem_wr,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       ex_valid,
   input  logic       ex_mem_rd,
   input  logic [4:0] ex_rd,
   output logic       load_use
);
   logic use_rs1_s;
   logic use_rs2_s;

   // LUI/AUIPC/JAL take no rs1; stores read rs2 even though operand B is the immediate.
   assign use_rs1_s = ~(lui | alu_src1);
   assign use_rs2_s = ~lui & (~alu_src2 | mem_wr);

   assign load_use = valid & ex_valid & ex_mem_rd & (ex_rd != 5'd0) &
                     ((use_rs1_s & (ex_rd == rs1)) | (use_rs2_s & (ex_rd == rs2)));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold/flush handling
// and a saturating count of load-use bubbles.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input logic           iClk,
   input logic           iRst,
   id_ex_stage_if.slave  bus
);
   import ctrl_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ctrl_t            ctrl_in_s;
   ctrl_t            ctrl_r;
   logic             load_use_s;
   logic             valid_r;
   logic [XLEN-1:0]  pc_r, rs1_data_r, rs2_data_r, imm_r;
   logic [4:0]       rs1_r, rs2_r, rd_r;
   logic [2:0]       funct3_r;
   logic             funct7b5_r;
   logic [CNT_W-1:0] bubble_cnt_r;

   assign ctrl_in_s = '{lui:        bus.iLui,
                        pc_src:     bus.iPcSrc,
                        mem_rd:     bus.iMemRd,
                        mem_wr:     bus.iMemWr,
                        mem_to_reg: bus.iMemtoReg,
                        alu_src1:   bus.iAluSrc1,
                        alu_src2:   bus.iAluSrc2,
                        reg_write:  bus.iRegWrite,
                        branch:     bus.iBranch,
                        jump:       bus.iJump,
                        alu_op:     bus.iAluOp};

   hazard_unit u_hazard (
      .valid     (bus.iValid),
      .lui       (bus.iLui),
      .alu_src1  (bus.iAluSrc1),
      .alu_src2  (bus.iAluSrc2),
      .mem_wr    (bus.iMemWr),
      .rs1       (bus.iRs1),
      .rs2       (bus.iRs2),
      .ex_valid  (valid_r),
      .ex_mem_rd (ctrl_r.mem_rd),
      .ex_rd     (rd_r),
      .load_use  (load_use_s)
   );

   // Pipeline register bank: reset > flush > hold > load-use bubble > load.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         valid_r      <= 1'b0;
         ctrl_r       <= CTRL_BUBBLE;
         pc_r         <= {XLEN{1'b0}};
         rs1_data_r   <= {XLEN{1'b0}};
         rs2_data_r   <= {XLEN{1'b0}};
         imm_r        <= {XLEN{1'b0}};
         rs1_r        <= 5'd0;
         rs2_r        <= 5'd0;
         rd_r         <= 5'd0;
         funct3_r     <= 3'd0;
         funct7b5_r   <= 1'b0;
         bubble_cnt_r <= {CNT_W{1'b0}};
      end else if (bus.iFlush) begin
         valid_r <= 1'b0;
         ctrl_r  <= CTRL_BUBBLE;
      end else if (bus.iExStall) begin
         valid_r <= valid_r;
      end else if (load_use_s) begin
         valid_r <= 1'b0;
         ctrl_r  <= CTRL_BUBBLE;
         if (bubble_cnt_r != CNT_MAX) begin
            bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
         end else begin
            bubble_cnt_r <= bubble_cnt_r;
         end
      end else begin
         valid_r    <= bus.iValid;
         ctrl_r     <= bus.iValid ? ctrl_in_s : CTRL_BUBBLE;
         pc_r       <= bus.iPc;
         rs1_data_r <= bus.iRs1Data;
         rs2_data_r <= bus.iRs2Data;
         imm_r      <= bus.iImm;
         rs1_r      <= bus.iRs1;
         rs2_r      <= bus.iRs2;
         rd_r       <= bus.iRd;
         funct3_r   <= bus.iFunct3;
         funct7b5_r <= bus.iFunct7b5;
      end
   end

   // A flush overrides any stall so the corrected fetch can proceed.
   assign bus.oStall     = ~iRst & ~bus.iFlush & (load_use_s | bus.iExStall);

   assign bus.oValid     = valid_r;
   assign bus.oLui       = ctrl_r.lui;
   assign bus.oPcSrc     = ctrl_r.pc_src;
   assign bus.oMemRd     = ctrl_r.mem_rd;
   assign bus.oMemWr     = ctrl_r.mem_wr;
   assign bus.oMemtoReg  = ctrl_r.mem_to_reg;
   assign bus.oAluSrc1   = ctrl_r.alu_src1;
   assign bus.oAluSrc2   = ctrl_r.alu_src2;
   assign bus.oRegWrite  = ctrl_r.reg_write;
   assign bus.oBranch    = ctrl_r.branch;
   assign bus.oJump      = ctrl_r.jump;
   assign bus.oAluOp     = ctrl_r.alu_op;
   assign bus.oPc        = pc_r;
   assign bus.oRs1Data   = rs1_data_r;
   assign bus.oRs2Data   = rs2_data_r;
   assign bus.oImm       = imm_r;
   assign bus.oRs1       = rs1_r;
   assign bus.oRs2       = rs2_r;
   assign bus.oRd        = rd_r;
   assign bus.oFunct3    = funct3_r;
   assign bus.oFunct7b5  = funct7b5_r;
   assign bus.oBubbleCnt = bubble_cnt_r;
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against an instruction-level reference model.
module tb_id_ex_stage;
   localparam int XLEN    = 32;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   localparam int K_LW = 0, K_SW = 1, K_ADD = 2, K_ADDI = 3;
   localparam int K_LUI = 4, K_AUIPC = 5, K_JAL = 6, K_BEQ = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference EX-slot contents
   logic             m_valid;
   logic [12:0]      m_ctrl;
   logic [XLEN-1:0]  m_pc, m_r1d, m_r2d, m_imm;
   logic [4:0]       m_rs1, m_rs2, m_rd;
   logic [2:0]       m_f3;
   logic             m_f7;
   int               m_cnt;

   id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [12:0] in_ctrl();
      return {bus.iLui, bus.iPcSrc, bus.iMemRd, bus.iMemWr, bus.iMemtoReg, bus.iAluSrc1,
              bus.iAluSrc2, bus.iRegWrite, bus.iBranch, bus.iJump, bus.iAluOp};
   endfunction

   function automatic logic [12:0] out_ctrl();
      return {bus.oLui, bus.oPcSrc, bus.oMemRd, bus.oMemWr, bus.oMemtoReg, bus.oAluSrc1,
              bus.oAluSrc2, bus.oRegWrite, bus.oBranch, bus.oJump, bus.oAluOp};
   endfunction

   // Does the decode instruction read the register the EX load is writing?
   function automatic logic model_load_use();
      logic use1, use2;
      use1 = !(bus.iLui || bus.iAluSrc1);
      use2 = !bus.iLui && (!bus.iAluSrc2 || bus.iMemWr);
      return bus.iValid && m_valid && m_ctrl[10] && (m_rd != 5'd0) &&
             ((use1 && (m_rd == bus.iRs1)) || (use2 && (m_rd == bus.iRs2)));
   endfunction

   task automatic set_ctl(input logic r, input logic fl, input logic hold);
      rst          = r;
      bus.iFlush   = fl;
      bus.iExStall = hold;
   endtask

   task automatic set_instr(input logic v, input int k, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
      {bus.iLui, bus.iPcSrc, bus.iMemRd, bus.iMemWr, bus.iMemtoReg, bus.iAluSrc1,
       bus.iAluSrc2, bus.iRegWrite, bus.iBranch, bus.iJump, bus.iAluOp} = 13'd0;
      case (k)
         K_LW:    begin bus.iMemRd = 1'b1; bus.iMemtoReg = 1'b1; bus.iAluSrc2 = 1'b1; bus.iRegWrite = 1'b1; end
         K_SW:    begin bus.iMemWr = 1'b1; bus.iAluSrc2 = 1'b1; end
         K_ADD:   begin bus.iRegWrite = 1'b1; bus.iAluOp = 3'b010; end
         K_ADDI:  begin bus.iAluSrc2 = 1'b1; bus.iRegWrite = 1'b1; bus.iAluOp = 3'b011; end
         K_LUI:   begin bus.iLui = 1'b1; bus.iAluSrc2 = 1'b1; bus.iRegWrite = 1'b1; end
         K_AUIPC: begin bus.iAluSrc1 = 1'b1; bus.iAluSrc2 = 1'b1; bus.iRegWrite = 1'b1; end
         K_JAL:   begin bus.iAluSrc1 = 1'b1; bus.iAluSrc2 = 1'b1; bus.iRegWrite = 1'b1;
                        bus.iJump = 1'b1; bus.iPcSrc = 1'b1; end
         K_BEQ:   begin bus.iBranch = 1'b1; bus.iAluOp = 3'b001; end
         default: begin bus.iAluOp = 3'b000; end
      endcase
      bus.iValid    = v;
      bus.iRd       = rd;
      bus.iRs1      = rs1;
      bus.iRs2      = rs2;
      bus.iPc       = $urandom;
      bus.iRs1Data  = $urandom;
      bus.iRs2Data  = $urandom;
      bus.iImm      = $urandom;
      bus.iFunct3   = 3'($urandom_range(0, 7));
      bus.iFunct7b5 = 1'($urandom_range(0, 1));
   endtask

   task automatic check_outputs();
      check_val("valid", 64'(bus.oValid), 64'(m_valid));
      check_val("ctrl", 64'(out_ctrl()), 64'(m_ctrl));
      check_val("bubble_cnt", 64'(bus.oBubbleCnt), 64'(m_cnt));
      if (m_valid) begin
         check_val("pc", 64'(bus.oPc), 64'(m_pc));
         check_val("rs1_data", 64'(bus.oRs1Data), 64'(m_r1d));
         check_val("rs2_data", 64'(bus.oRs2Data), 64'(m_r2d));
         check_val("imm", 64'(bus.oImm), 64'(m_imm));
         check_val("idx", 64'({bus.oRs1, bus.oRs2, bus.oRd}), 64'({m_rs1, m_rs2, m_rd}));
         check_val("funct", 64'({bus.oFunct3, bus.oFunct7b5}), 64'({m_f3, m_f7}));
      end
   endtask

   // One clock: check oStall before the edge, advance the model, check the registers after.
   task automatic cycle();
      logic lu;
      #1;
      lu = model_load_use();
      check_val("stall", 64'(bus.oStall),
                64'(!rst && !bus.iFlush && (lu || bus.iExStall)));
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0; m_ctrl = 13'd0; m_cnt = 0;
         m_pc = '0; m_r1d = '0; m_r2d = '0; m_imm = '0;
         m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_f3 = 3'd0; m_f7 = 1'b0;
      end else if (bus.iFlush) begin
         m_valid = 1'b0; m_ctrl = 13'd0;
      end else if (bus.iExStall) begin
         m_valid = m_valid;
      end else if (lu) begin
         m_valid = 1'b0; m_ctrl = 13'd0;
         if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
         m_valid = bus.iValid;
         m_ctrl  = bus.iValid ? in_ctrl() : 13'd0;
         m_pc = bus.iPc; m_r1d = bus.iRs1Data; m_r2d = bus.iRs2Data; m_imm = bus.iImm;
         m_rs1 = bus.iRs1; m_rs2 = bus.iRs2; m_rd = bus.iRd;
         m_f3 = bus.iFunct3; m_f7 = bus.iFunct7b5;
      end
      #1;
      check_outputs();
   endtask

   int sat_exp [5] = '{1, 2, 3, 3, 3};
   int cnt_before;

   initial begin
      m_valid = 1'b0; m_ctrl = 13'd0; m_cnt = 0;
      m_pc = '0; m_r1d = '0; m_r2d = '0; m_imm = '0;
      m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_f3 = 3'd0; m_f7 = 1'b0;

      // Reset with every input driven high
      set_ctl(1'b1, 1'b1, 1'b1);
      set_instr(1'b1, K_LW, 5'd31, 5'd31, 5'd31);
      {bus.iLui, bus.iPcSrc, bus.iMemRd, bus.iMemWr, bus.iMemtoReg, bus.iAluSrc1,
       bus.iAluSrc2, bus.iRegWrite, bus.iBranch, bus.iJump, bus.iAluOp} = 13'h1fff;
      bus.iPc = '1; bus.iRs1Data = '1; bus.iRs2Data = '1; bus.iImm = '1;
      bus.iFunct3 = 3'd7; bus.iFunct7b5 = 1'b1;
      cycle();
      cycle();
      check_val("rst_stall", 64'(bus.oStall), 64'd0);
      check_val("rst_fields", 64'({bus.oPc, bus.oRd, bus.oRs1, bus.oRs2}), 64'd0);
      check_val("rst_cnt", 64'(bus.oBubbleCnt), 64'd0);

      // Load-use on rs1
      set_ctl(1'b0, 1'b0, 1'b0);
      set_instr(1'b1, K_LW, 5'd5, 5'd1, 5'd0);  cycle();
      set_instr(1'b1, K_ADD, 5'd6, 5'd5, 5'd1);
      #1 check_val("lu_rs1_stall", 64'(bus.oStall), 64'd1);
      cycle();
      check_val("lu_rs1_bubble", 64'({bus.oValid, out_ctrl()}), 64'd0);
      check_val("lu_rs1_cnt", 64'(bus.oBubbleCnt), 64'd1);
      cycle();
      check_val("lu_rs1_rd", 64'({bus.oRd, bus.oRegWrite}), 64'({5'd6, 1'b1}));

      // No false hazards
      set_instr(1'b1, K_LW, 5'd0, 5'd1, 5'd0);  cycle();
      set_instr(1'b1, K_ADD, 5'd6, 5'd0, 5'd0);
      #1 check_val("x0_stall", 64'(bus.oStall), 64'd0);
      cycle();
      set_instr(1'b1, K_LW, 5'd5, 5'd1, 5'd0);  cycle();
      set_instr(1'b1, K_LUI, 5'd5, 5'd5, 5'd5);
      #1 check_val("lui_stall", 64'(bus.oStall), 64'd0);
      cycle();
      set_instr(1'b1, K_LW, 5'd5, 5'd1, 5'd0);  cycle();
      set_instr(1'b1, K_ADDI, 5'd7, 5'd1, 5'd5);
      #1 check_val("addi_stall", 64'(bus.oStall), 64'd0);
      cycle();

      // Store reading the loaded register through rs2
      set_instr(1'b1, K_LW, 5'd3, 5'd1, 5'd0);  cycle();
      set_instr(1'b1, K_SW, 5'd0, 5'd2, 5'd3);
      #1 check_val("sw_stall", 64'(bus.oStall), 64'd1);
      cycle();
      check_val("sw_bubble", 64'(bus.oValid), 64'd0);
      cycle();
      check_val("sw_loaded", 64'({bus.oValid, bus.oMemWr}), 64'({1'b1, 1'b1}));

      // Hold for three cycles, then flush while a load-use is pending
      set_instr(1'b1, K_LW, 5'd5, 5'd1, 5'd0);  cycle();
      set_instr(1'b1, K_ADD, 5'd6, 5'd5, 5'd1);
      set_ctl(1'b0, 1'b0, 1'b1);
      cnt_before = m_cnt;
      for (int i = 0; i < 3; i++) begin
         #1 check_val("hold_stall", 64'(bus.oStall), 64'd1);
         cycle();
         check_val("hold_rd", 64'({bus.oValid, bus.oRd, bus.oMemRd}), 64'({1'b1, 5'd5, 1'b1}));
      end
      set_ctl(1'b0, 1'b1, 1'b0);
      #1 check_val("flush_stall", 64'(bus.oStall), 64'd0);
      cycle();
      check_val("flush_valid", 64'(bus.oValid), 64'd0);
      check_val("flush_cnt", 64'(bus.oBubbleCnt), 64'(cnt_before));

      // Counter saturation from a clean reset
      set_ctl(1'b1, 1'b0, 1'b0);  cycle();
      set_ctl(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         set_instr(1'b1, K_LW, 5'd5, 5'd1, 5'd0);  cycle();
         set_instr(1'b1, K_ADD, 5'd6, 5'd5, 5'd1); cycle();
         check_val("sat_cnt", 64'(bus.oBubbleCnt), 64'(sat_exp[i]));
      end

      // Random traffic over a small register range to provoke hazards
      for (int n = 0; n < 400; n++) begin
         set_ctl(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 6) == 0));
         set_instr(1'($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
